// File: rtl/fft_irq_pkg.sv
// fft_irq_pkg: shared FSM states, register map and reset values for the FFT interrupt controller
package fft_irq_pkg;
   typedef enum logic [1:0] {IRQ_IDLE, IRQ_ACCUM, IRQ_ASSERT} irq_state_t;
   localparam logic [2:0] ADDR_STATUS = 3'd0;
   localparam logic [2:0] ADDR_MASK   = 3'd1;
   localparam logic [2:0] ADDR_THR    = 3'd2;
   localparam logic [2:0] ADDR_TMO    = 3'd3;
   localparam logic [2:0] ADDR_TEST   = 3'd4;
   localparam int THR_RST = 1;
   localparam int TMO_RST = 0;
endpackage

// File: rtl/fft_irq_regs.sv
// fft_irq_regs: edge detect, sticky W1C status, mask/thr/tmo registers and registered read port
// ports: clk_i/reset_i, int_status_i, reg_* bus, status_o/mask_o/thr_o/tmo_o/rise_o to the FSM
module fft_irq_regs import fft_irq_pkg::*; #(
   parameter int NUM_SRC = 8,
   parameter int CNT_W   = 4,
   parameter int TMO_W   = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [NUM_SRC-1:0] int_status_i,
   input  logic               reg_wr_i,
   input  logic               reg_rd_i,
   input  logic [2:0]         reg_addr_i,
   input  logic [31:0]        reg_wdata_i,
   output logic [31:0]        reg_rdata_o,
   output logic               reg_rvalid_o,
   output logic [NUM_SRC-1:0] status_o,
   output logic [NUM_SRC-1:0] mask_o,
   output logic [CNT_W-1:0]   thr_o,
   output logic [TMO_W-1:0]   tmo_o,
   output logic [NUM_SRC-1:0] rise_o
);
   logic [NUM_SRC-1:0] in_q, in_d, status_q, status_d, mask_q, mask_d, rise, w1c, w1s;
   logic [CNT_W-1:0]   thr_q, thr_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [31:0]        rdata_q, rdata_d, rd_val;
   logic               rvalid_q, rvalid_d;
   logic               unused_wdata;
   assign unused_wdata = ^reg_wdata_i[31:TMO_W];
   always_comb begin
      in_d     = int_status_i;
      rise     = int_status_i & ~in_q;
      w1c      = (reg_wr_i && reg_addr_i == ADDR_STATUS) ? reg_wdata_i[NUM_SRC-1:0] : '0;
      w1s      = (reg_wr_i && reg_addr_i == ADDR_TEST) ? reg_wdata_i[NUM_SRC-1:0] : '0;
      // sets are OR-ed after the clear so a same-cycle rise survives its own W1C
      status_d = (status_q & ~w1c) | rise | w1s;
      mask_d   = (reg_wr_i && reg_addr_i == ADDR_MASK) ? reg_wdata_i[NUM_SRC-1:0] : mask_q;
      thr_d    = (reg_wr_i && reg_addr_i == ADDR_THR) ? reg_wdata_i[CNT_W-1:0] : thr_q;
      tmo_d    = (reg_wr_i && reg_addr_i == ADDR_TMO) ? reg_wdata_i[TMO_W-1:0] : tmo_q;
      rd_val   = reg_addr_i == ADDR_STATUS ? 32'(status_q) :
                 reg_addr_i == ADDR_MASK   ? 32'(mask_q)   :
                 reg_addr_i == ADDR_THR    ? 32'(thr_q)    :
                 reg_addr_i == ADDR_TMO    ? 32'(tmo_q)    : '0;
      rdata_d  = reg_rd_i ? rd_val : '0;
      rvalid_d = reg_rd_i;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         in_q     <= '0;
         status_q <= '0;
         mask_q   <= '0;
         thr_q    <= CNT_W'(THR_RST);
         tmo_q    <= TMO_W'(TMO_RST);
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         in_q     <= in_d;
         status_q <= status_d;
         mask_q   <= mask_d;
         thr_q    <= thr_d;
         tmo_q    <= tmo_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end
   assign reg_rdata_o  = rdata_q;
   assign reg_rvalid_o = rvalid_q;
   assign status_o     = status_q;
   assign mask_o       = mask_q;
   assign thr_o        = thr_q;
   assign tmo_o        = tmo_q;
   assign rise_o       = rise;
endmodule

// File: rtl/fft_irq_ctrl.sv
// fft_irq_ctrl: masked, coalesced level interrupt from the FFT control unit's pending vector
// ports: clk_i/reset_i, int_status_i, reg_wr_i/reg_rd_i/reg_addr_i/reg_wdata_i, reg_rdata_o/reg_rvalid_o, irq_o
module fft_irq_ctrl import fft_irq_pkg::*; #(
   parameter int NUM_SRC = 8,
   parameter int CNT_W   = 4,
   parameter int TMO_W   = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [NUM_SRC-1:0] int_status_i,
   input  logic               reg_wr_i,
   input  logic               reg_rd_i,
   input  logic [2:0]         reg_addr_i,
   input  logic [31:0]        reg_wdata_i,
   output logic [31:0]        reg_rdata_o,
   output logic               reg_rvalid_o,
   output logic               irq_o
);
   logic [NUM_SRC-1:0] status, mask, rise;
   logic [CNT_W-1:0]   thr, evt_q, evt_d, evt_base;
   logic [TMO_W-1:0]   tmo, tmr_q, tmr_d;
   irq_state_t         state_q, state_d;
   logic               irq_q, irq_d, pend, fire, evt;
   fft_irq_regs #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .TMO_W(TMO_W)) u_regs (
      .clk_i(clk_i), .reset_i(reset_i), .int_status_i(int_status_i),
      .reg_wr_i(reg_wr_i), .reg_rd_i(reg_rd_i), .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
      .reg_rdata_o(reg_rdata_o), .reg_rvalid_o(reg_rvalid_o),
      .status_o(status), .mask_o(mask), .thr_o(thr), .tmo_o(tmo), .rise_o(rise)
   );
   always_comb begin
      pend     = |(status & mask);
      evt      = |(rise & mask);
      // thr of 0 or 1 fires on any pending status, including a freshly unmasked one
      fire     = thr <= CNT_W'(1) || evt_q >= thr || (tmo != '0 && tmr_q >= tmo);
      // IDLE can jump straight to ASSERT so a thr<=1 event reaches irq_o two cycles after the rise
      state_d  = !pend ? IRQ_IDLE : (state_q == IRQ_ASSERT || fire) ? IRQ_ASSERT : IRQ_ACCUM;
      // counters clear on return to IDLE, but an event arriving that same cycle is kept
      evt_base = state_d == IRQ_IDLE ? '0 : evt_q;
      evt_d    = evt_base + CNT_W'(evt && !(&evt_base));
      tmr_d    = (state_q == IRQ_ACCUM && state_d == IRQ_ACCUM) ? tmr_q + TMO_W'(!(&tmr_q)) : '0;
      irq_d    = state_d == IRQ_ASSERT;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IRQ_IDLE;
         evt_q   <= '0;
         tmr_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         evt_q   <= evt_d;
         tmr_q   <= tmr_d;
         irq_q   <= irq_d;
      end
   end
   assign irq_o = irq_q;
endmodule
